axi_sram_responder: RTL and testbench
=====================================

Name: axi_sram_responder

Overview:
- AXI3-style slave (responder) that terminates the external memory-side AXI port and serves bursts from on-chip block RAM.
- Mirrors the top-level AXI master port set (4-bit len, 32-bit data, ID fields).
- Lets the full GPGPU + bridge path be closed on-chip for FPGA bring-up and simulation without the SDRAM/HPS fabric.
- Independent read and write channels share one dual-port memory (one write port, one read port).

Parameters:
- AXI_ID_W, 4, width of all ID fields.
- AXI_ADDRESS_W, 32, byte address width.
- AXI_DATA_W, 32, data width; fixed at 32 for this block.
- AXI_NUMBYTES, 4, strobe width (AXI_DATA_W/8).
- MEM_WORDS, 'h4000, memory depth in 32-bit words.
- BASE_ADDRESS, 32'h00040000, byte address mapped to word 0.

Ports:
- clk in 1: single clock.
- reset in 1: synchronous, active-high.
- axs_awid in AXI_ID_W, axs_awaddr in AXI_ADDRESS_W, axs_awlen in 4, axs_awsize in 3, axs_awburst in 2, axs_awvalid in 1, axs_awready out 1: write address channel.
- axs_wdata in 32, axs_wstrb in 4, axs_wlast in 1, axs_wvalid in 1, axs_wready out 1: write data channel.
- axs_bid out AXI_ID_W, axs_bresp out 2, axs_bvalid out 1, axs_bready in 1: write response channel.
- axs_arid in AXI_ID_W, axs_araddr in AXI_ADDRESS_W, axs_arlen in 4, axs_arsize in 3, axs_arburst in 2, axs_arvalid in 1, axs_arready out 1: read address channel.
- axs_rid out AXI_ID_W, axs_rdata out 32, axs_rresp out 2, axs_rlast out 1, axs_rvalid out 1, axs_rready in 1: read data channel.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset: all FSMs go to IDLE. Reset values:
  - axs_awready=1, axs_arready=1.
  - axs_wready=0, axs_bvalid=0, axs_rvalid=0, axs_rlast=0.
  - axs_bresp=0, axs_rresp=0, axs_bid=0, axs_rid=0, axs_rdata=0.
  - Memory contents are not reset.
  - Reset mid-burst abandons the burst: no further beats, no response.
- Address decode:
  - word = (addr - BASE_ADDRESS) >> 2.
  - In range iff addr >= BASE_ADDRESS and word < MEM_WORDS.
  - Only INCR (burst=01) with size=3'b010 is supported.
  - Any other burst type or size makes every beat of that burst an error beat.
- Beat address increments by 1 word per beat.
- Range is checked per beat, so a burst crossing the memory end errors only the out-of-range beats.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On aw handshake, latch id, word address, len, error flag; next cycle W_DATA.
  - W_DATA: wready=1. Each w handshake writes the beat if in range and legal; error beats are dropped and set a sticky error bit. Beat counter runs 0..len.
  - On beat == len, go to W_RESP regardless of wlast. The beat counter is authoritative.
  - wlast mismatch (wlast=1 before the final beat, or wlast=0 on it) sets the sticky error bit.
  - W_RESP: bvalid=1, bid=latched id, bresp=2'b10 (SLVERR) if sticky error else 2'b00. bid/bresp are held until bready. On handshake, go to W_IDLE; awready reasserts the next cycle.
  - Minimum write turnaround for a 1-beat burst: aw at cycle 0, w at cycle 1, bvalid at cycle 2.
- Read FSM, R_IDLE -> R_BURST:
  - R_IDLE: arready=1. On ar handshake, latch id, word address, len. rvalid rises the cycle after the handshake, carrying beat 0.
  - R_BURST: rdata=mem[word], rresp=00, or rdata=0 with rresp=2'b10 for an error beat. rid=latched id. rlast=1 on beat len.
  - rdata, rresp and rlast are stable while rvalid && !rready.
  - Memory read address = next word when (rvalid && rready), else current word. This sustains 1 beat/cycle with rready held high.
  - On the final-beat handshake: rvalid=0, go to R_IDLE, arready=1 the next cycle.
- Read and write paths run concurrently.
  - Same-cycle write and read to the same word: the read returns old data (read-before-write).
- Only one outstanding transaction per direction; no interleaving or reordering.

Optional Feature:
- Macro: AXI_SRAM_WSTRB_EN.
- Defined: per-byte write enables; byte i is written only if axs_wstrb[i]=1. wstrb=0 writes nothing and is not an error.
- Undefined: axs_wstrb is ignored and every accepted in-range beat writes all 4 bytes.

Test Plan:
- Single write, then read:
  - Stimulus: aw addr 0x00040010 len 0, w data 0xDEADBEEF; ar same address, len 0.
  - Required: bresp 00 at cycle 2; rdata 0xDEADBEEF, rlast=1, rresp 00.
- 16-beat burst:
  - Stimulus: write burst len 15 at 0x00040000, data 0..15; read back len 15 with rready held high.
  - Required: 16 consecutive rvalid cycles, data 0..15, rlast only on beat 15.
- Read backpressure:
  - Stimulus: len 3 read with rready toggled 1,0,0,1,...
  - Required: rdata held stable across the stalls, all 4 beats in order, no beat lost or duplicated.
- Range boundary:
  - Stimulus: write len 3 starting at word MEM_WORDS-2; read back the same burst.
  - Required: bresp 10; first 2 words written; read beats 2-3 return rdata 0 with rresp 10.
- Strobe (AXI_SRAM_WSTRB_EN defined):
  - Stimulus: preload 0x11223344, then write 0xAABBCCDD with wstrb 4'b0101.
  - Required: readback 0x11BB33DD. With the macro undefined, readback 0xAABBCCDD.
- Reset and concurrency:
  - Stimulus: assert reset during beat 2 of a len 7 read.
  - Required: rvalid=0 the next cycle, arready=1. Then issue simultaneous aw and ar handshakes.
  - Required: both complete independently, with bid and rid matching their requests.

Source files
------------

// File: rtl/axi_sram_responder.sv
// AXI3-style slave serving INCR bursts from on-chip dual-port block RAM.
// Ports: clk, reset (sync, high), AXI aw/w/b/ar/r slave channels (axs_*).
// Option: define AXI_SRAM_WSTRB_EN for per-byte write enables via wstrb.
module axi_sram_responder #(
    parameter int                     AXI_ID_W      = 4,
    parameter int                     AXI_ADDRESS_W = 32,
    parameter int                     AXI_DATA_W    = 32,
    parameter int                     AXI_NUMBYTES  = 4,
    parameter int                     MEM_WORDS     = 'h4000,
    parameter logic [AXI_ADDRESS_W-1:0] BASE_ADDRESS = 32'h00040000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [AXI_ID_W-1:0]      axs_awid,
    input  logic [AXI_ADDRESS_W-1:0] axs_awaddr,
    input  logic [3:0]               axs_awlen,
    input  logic [2:0]               axs_awsize,
    input  logic [1:0]               axs_awburst,
    input  logic                     axs_awvalid,
    output logic                     axs_awready,
    input  logic [AXI_DATA_W-1:0]    axs_wdata,
    input  logic [AXI_NUMBYTES-1:0]  axs_wstrb,
    input  logic                     axs_wlast,
    input  logic                     axs_wvalid,
    output logic                     axs_wready,
    output logic [AXI_ID_W-1:0]      axs_bid,
    output logic [1:0]               axs_bresp,
    output logic                     axs_bvalid,
    input  logic                     axs_bready,
    input  logic [AXI_ID_W-1:0]      axs_arid,
    input  logic [AXI_ADDRESS_W-1:0] axs_araddr,
    input  logic [3:0]               axs_arlen,
    input  logic [2:0]               axs_arsize,
    input  logic [1:0]               axs_arburst,
    input  logic                     axs_arvalid,
    output logic                     axs_arready,
    output logic [AXI_ID_W-1:0]      axs_rid,
    output logic [AXI_DATA_W-1:0]    axs_rdata,
    output logic [1:0]               axs_rresp,
    output logic                     axs_rlast,
    output logic                     axs_rvalid,
    input  logic                     axs_rready
);

    localparam int AW    = AXI_ADDRESS_W;
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [AW-1:0] MEM_W = AW'(MEM_WORDS);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE  = 1'b0;
    localparam logic       R_BURST = 1'b1;

    // Signed word offset from BASE_ADDRESS; MSB set means below base.
    function automatic logic [AW-1:0] word_of(
        input logic [AW-1:0] a
    );
        logic [AW:0] d;
        d = {1'b0, a} - {1'b0, BASE_ADDRESS};
        return {d[AW], d[AW:2]};
    endfunction

    function automatic logic in_range(input logic [AW-1:0] w);
        return !w[AW-1] && (w < MEM_W);
    endfunction

    function automatic logic legal(
        input logic [1:0] burst,
        input logic [2:0] size
    );
        return (burst == 2'b01) && (size == 3'b010);
    endfunction

    logic [AXI_DATA_W-1:0] mem [MEM_WORDS];
    logic [AXI_DATA_W-1:0] mem_q;

    // ---------------- write path ----------------
    logic [1:0]          w_state;
    logic [AXI_ID_W-1:0] w_id;
    logic [AW-1:0]       w_word;
    logic [3:0]          w_len;
    logic [3:0]          w_beat;
    logic                w_cfg_err;
    logic                w_err;
    logic [AXI_ID_W-1:0] bid_q;
    logic [1:0]          bresp_q;

    logic             w_last_beat;
    logic             w_beat_ok;
    logic             w_beat_err;
    logic             mem_we;
    logic [IDX_W-1:0] w_idx;

    assign w_last_beat = (w_beat == w_len);
    assign w_beat_ok   = !w_cfg_err && in_range(w_word);
    assign w_beat_err  = !w_beat_ok || (axs_wlast != w_last_beat);
    assign mem_we      = !reset && (w_state == W_DATA)
                       && axs_wvalid && w_beat_ok;
    assign w_idx       = w_word[IDX_W-1:0];

    assign axs_awready = (w_state == W_IDLE);
    assign axs_wready  = (w_state == W_DATA);
    assign axs_bvalid  = (w_state == W_RESP);
    assign axs_bid     = bid_q;
    assign axs_bresp   = bresp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state   <= W_IDLE;
            w_id      <= '0;
            w_word    <= '0;
            w_len     <= '0;
            w_beat    <= '0;
            w_cfg_err <= 1'b0;
            w_err     <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'b00;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (axs_awvalid) begin
                        w_id      <= axs_awid;
                        w_word    <= word_of(axs_awaddr);
                        w_len     <= axs_awlen;
                        w_beat    <= '0;
                        w_cfg_err <= !legal(axs_awburst,
                                            axs_awsize);
                        w_err     <= 1'b0;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axs_wvalid) begin
                        // Beat count, not wlast, ends the burst.
                        if (w_last_beat) begin
                            w_state <= W_RESP;
                            bid_q   <= w_id;
                            bresp_q <= (w_err || w_beat_err)
                                     ? 2'b10 : 2'b00;
                        end else begin
                            w_beat <= w_beat + 4'd1;
                            w_word <= w_word + AW'(1);
                            w_err  <= w_err | w_beat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (axs_bready) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

`ifdef AXI_SRAM_WSTRB_EN
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < AXI_NUMBYTES; i++) begin
                if (axs_wstrb[i]) begin
                    mem[w_idx][8*i +: 8] <= axs_wdata[8*i +: 8];
                end
            end
        end
    end
`else
    logic unused_wstrb;
    assign unused_wstrb = ^axs_wstrb;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[w_idx] <= axs_wdata;
        end
    end
`endif

    // ---------------- read path ----------------
    logic                r_state;
    logic [AXI_ID_W-1:0] r_id;
    logic [AW-1:0]       r_word;
    logic [3:0]          r_len;
    logic [3:0]          r_beat;
    logic                r_cfg_err;

    logic             r_beat_ok;
    logic             rd_en;
    logic [AW-1:0]    ar_word;
    logic [AW-1:0]    rd_word;
    logic [IDX_W-1:0] rd_idx;

    assign ar_word   = word_of(axs_araddr);
    assign r_beat_ok = !r_cfg_err && in_range(r_word);

    // Prefetch the next word on a beat handshake so rready held
    // high streams one beat per cycle; a stall freezes mem_q.
    assign rd_en   = (r_state == R_IDLE) || axs_rready;
    assign rd_word = (r_state == R_IDLE) ? ar_word
                   : (axs_rready ? r_word + AW'(1) : r_word);
    assign rd_idx  = rd_word[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rd_en) begin
            mem_q <= mem[rd_idx];
        end
    end

    assign axs_arready = (r_state == R_IDLE);
    assign axs_rvalid  = (r_state == R_BURST);
    assign axs_rid     = r_id;
    assign axs_rlast   = axs_rvalid && (r_beat == r_len);
    assign axs_rresp   = (axs_rvalid && !r_beat_ok)
                       ? 2'b10 : 2'b00;
    assign axs_rdata   = (axs_rvalid && r_beat_ok)
                       ? mem_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= R_IDLE;
            r_id      <= '0;
            r_word    <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (axs_arvalid) begin
                        r_id      <= axs_arid;
                        r_word    <= ar_word;
                        r_len     <= axs_arlen;
                        r_beat    <= '0;
                        r_cfg_err <= !legal(axs_arburst,
                                            axs_arsize);
                        r_state   <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (axs_rready) begin
                        if (r_beat == r_len) begin
                            r_state <= R_IDLE;
                        end else begin
                            r_beat <= r_beat + 4'd1;
                            r_word <= r_word + AW'(1);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Self-checking bench for axi_sram_responder.
// Directed and random bursts checked against a word-array memory model.
module tb_axi_sram_responder;

    localparam logic [31:0] BASE = 32'h00040000;
    localparam int          MEMW = 'h4000;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  axs_awid;
    logic [31:0] axs_awaddr;
    logic [3:0]  axs_awlen;
    logic [2:0]  axs_awsize;
    logic [1:0]  axs_awburst;
    logic        axs_awvalid;
    logic        axs_awready;
    logic [31:0] axs_wdata;
    logic [3:0]  axs_wstrb;
    logic        axs_wlast;
    logic        axs_wvalid;
    logic        axs_wready;
    logic [3:0]  axs_bid;
    logic [1:0]  axs_bresp;
    logic        axs_bvalid;
    logic        axs_bready;
    logic [3:0]  axs_arid;
    logic [31:0] axs_araddr;
    logic [3:0]  axs_arlen;
    logic [2:0]  axs_arsize;
    logic [1:0]  axs_arburst;
    logic        axs_arvalid;
    logic        axs_arready;
    logic [3:0]  axs_rid;
    logic [31:0] axs_rdata;
    logic [1:0]  axs_rresp;
    logic        axs_rlast;
    logic        axs_rvalid;
    logic        axs_rready;

    axi_sram_responder dut (
        .clk         (clk),
        .reset       (reset),
        .axs_awid    (axs_awid),
        .axs_awaddr  (axs_awaddr),
        .axs_awlen   (axs_awlen),
        .axs_awsize  (axs_awsize),
        .axs_awburst (axs_awburst),
        .axs_awvalid (axs_awvalid),
        .axs_awready (axs_awready),
        .axs_wdata   (axs_wdata),
        .axs_wstrb   (axs_wstrb),
        .axs_wlast   (axs_wlast),
        .axs_wvalid  (axs_wvalid),
        .axs_wready  (axs_wready),
        .axs_bid     (axs_bid),
        .axs_bresp   (axs_bresp),
        .axs_bvalid  (axs_bvalid),
        .axs_bready  (axs_bready),
        .axs_arid    (axs_arid),
        .axs_araddr  (axs_araddr),
        .axs_arlen   (axs_arlen),
        .axs_arsize  (axs_arsize),
        .axs_arburst (axs_arburst),
        .axs_arvalid (axs_arvalid),
        .axs_arready (axs_arready),
        .axs_rid     (axs_rid),
        .axs_rdata   (axs_rdata),
        .axs_rresp   (axs_rresp),
        .axs_rlast   (axs_rlast),
        .axs_rvalid  (axs_rvalid),
        .axs_rready  (axs_rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [int];
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];
    logic [31:0] last_rdata;
    logic [1:0]  last_bresp;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    function automatic bit beat_ok(input longint a,
                                   input logic [1:0] burst,
                                   input logic [2:0] size);
        return burst == 2'b01 && size == 3'b010
            && a >= longint'(BASE)
            && ((a - longint'(BASE)) >> 2) < longint'(MEMW);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [3:0]  en;
        logic [31:0] r;
`ifdef AXI_SRAM_WSTRB_EN
        en = strb;
`else
        en = strb | 4'hF;
`endif
        r = old;
        for (int b = 0; b < 4; b++)
            if (en[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic do_write(input logic [3:0] id,
                            input logic [31:0] addr,
                            input int len,
                            input logic [1:0] burst,
                            input logic [2:0] size,
                            input int bad_last,
                            output int aw_c,
                            output int w_c,
                            output int b_c);
        int     t;
        int     w;
        longint a;
        bit     err;
        axs_awid    = id;
        axs_awaddr  = addr;
        axs_awlen   = len[3:0];
        axs_awburst = burst;
        axs_awsize  = size;
        axs_awvalid = 1'b1;
        t = 0;
        while (!axs_awready && t < 50) begin step(); t++; end
        check("aw_wait", 32'(t < 50), 1);
        aw_c = cyc;
        step();
        axs_awvalid = 1'b0;
        w_c = -1;
        for (int i = 0; i <= len; i++) begin
            axs_wdata  = wdat[i];
            axs_wstrb  = wstb[i];
            axs_wlast  = (i == len) != (i == bad_last);
            axs_wvalid = 1'b1;
            t = 0;
            while (!axs_wready && t < 50) begin step(); t++; end
            check("w_wait", 32'(t < 50), 1);
            if (i == 0) w_c = cyc;
            step();
        end
        axs_wvalid = 1'b0;
        axs_wlast  = 1'b0;
        err = (bad_last >= 0 && bad_last <= len);
        for (int i = 0; i <= len; i++) begin
            a = longint'(addr) + 4 * i;
            if (beat_ok(a, burst, size)) begin
                w = int'((a - longint'(BASE)) >> 2);
                ref_mem[w] = merge(ref_mem.exists(w) ? ref_mem[w]
                                   : 32'h0, wdat[i], wstb[i]);
            end else begin
                err = 1'b1;
            end
        end
        axs_bready = 1'b1;
        t = 0;
        while (!axs_bvalid && t < 50) begin step(); t++; end
        check("b_wait", 32'(t < 50), 1);
        b_c = cyc;
        last_bresp = axs_bresp;
        check("bresp", axs_bresp, err ? 32'd2 : 32'd0);
        check("bid", axs_bid, id);
        step();
        axs_bready = 1'b0;
        check("awready_after_b", axs_awready, 1);
    endtask

    task automatic do_read(input logic [3:0] id,
                           input logic [31:0] addr,
                           input int len,
                           input logic [1:0] burst,
                           input logic [2:0] size,
                           input int mode,
                           output int ar_c,
                           output int first_c,
                           output int last_c);
        int          t, beats, k, w;
        bit          held, rr, ok;
        logic [31:0] hd;
        logic [1:0]  hr;
        logic        hl;
        longint      a;
        axs_arid    = id;
        axs_araddr  = addr;
        axs_arlen   = len[3:0];
        axs_arburst = burst;
        axs_arsize  = size;
        axs_arvalid = 1'b1;
        t = 0;
        while (!axs_arready && t < 50) begin step(); t++; end
        check("ar_wait", 32'(t < 50), 1);
        ar_c = cyc;
        step();
        axs_arvalid = 1'b0;
        beats = 0; k = 0; t = 0; held = 0;
        first_c = -1; last_c = -1;
        hd = '0; hr = '0; hl = 1'b0;
        while (beats <= len && t < 200) begin
            rr = (mode == 0) || (k % 4 == 0) || (k % 4 == 3);
            axs_rready = rr;
            if (axs_rvalid) begin
                if (first_c < 0) first_c = cyc;
                if (held) begin
                    check("r_hold_data", axs_rdata, hd);
                    check("r_hold_resp", axs_rresp, hr);
                    check("r_hold_last", axs_rlast, hl);
                end
                if (rr) begin
                    a  = longint'(addr) + 4 * beats;
                    ok = beat_ok(a, burst, size);
                    check("rresp", axs_rresp, ok ? 32'd0 : 32'd2);
                    check("rlast", axs_rlast, 32'(beats == len));
                    check("rid", axs_rid, id);
                    if (!ok) begin
                        check("rdata_err", axs_rdata, 0);
                    end else begin
                        w = int'((a - longint'(BASE)) >> 2);
                        if (ref_mem.exists(w))
                            check("rdata", axs_rdata, ref_mem[w]);
                    end
                    last_rdata = axs_rdata;
                    last_c = cyc;
                    beats++;
                    held = 0;
                end else begin
                    held = 1;
                    hd = axs_rdata;
                    hr = axs_rresp;
                    hl = axs_rlast;
                end
            end
            step();
            k++;
            t++;
        end
        axs_rready = 1'b0;
        check("r_beats", beats, len + 1);
        check("rvalid_after", axs_rvalid, 0);
        check("arready_after", axs_arready, 1);
    endtask

    int          awc, wc, bc, arc, fc, lc;
    int          awc2, wc2, bc2, arc2, fc2, lc2;
    int          beats, t, len, word;
    logic [31:0] addr;
    logic [31:0] exp_strobe;

    initial begin
        reset = 1'b1;
        axs_awid = '0; axs_awaddr = '0; axs_awlen = '0;
        axs_awsize = '0; axs_awburst = '0; axs_awvalid = 1'b0;
        axs_wdata = '0; axs_wstrb = '0; axs_wlast = 1'b0;
        axs_wvalid = 1'b0; axs_bready = 1'b0;
        axs_arid = '0; axs_araddr = '0; axs_arlen = '0;
        axs_arsize = '0; axs_arburst = '0; axs_arvalid = 1'b0;
        axs_rready = 1'b0;
        step();
        step();
        check("rst_awready", axs_awready, 1);
        check("rst_arready", axs_arready, 1);
        check("rst_wready", axs_wready, 0);
        check("rst_bvalid", axs_bvalid, 0);
        check("rst_rvalid", axs_rvalid, 0);
        check("rst_rlast", axs_rlast, 0);
        check("rst_bresp", axs_bresp, 0);
        check("rst_rresp", axs_rresp, 0);
        check("rst_bid", axs_bid, 0);
        check("rst_rid", axs_rid, 0);
        check("rst_rdata", axs_rdata, 0);
        reset = 1'b0;
        step();

        // single write then read, with latency checks
        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        do_write(4'h1, BASE + 32'h10, 0, 2'b01, 3'b010, -1,
                 awc, wc, bc);
        check("t1_w_lat", 32'(wc - awc), 1);
        check("t1_b_lat", 32'(bc - awc), 2);
        check("t1_bresp", last_bresp, 0);
        do_read(4'h2, BASE + 32'h10, 0, 2'b01, 3'b010, 0,
                arc, fc, lc);
        check("t1_r_lat", 32'(fc - arc), 1);
        check("t1_rdata", last_rdata, 32'hDEADBEEF);

        // 16-beat burst streaming
        for (int i = 0; i < 16; i++) begin
            wdat[i] = 32'(i); wstb[i] = 4'hF;
        end
        do_write(4'h3, BASE, 15, 2'b01, 3'b010, -1, awc, wc, bc);
        do_read(4'h4, BASE, 15, 2'b01, 3'b010, 0, arc, fc, lc);
        check("t2_consec", 32'(lc - fc), 15);
        check("t2_last", last_rdata, 15);

        // read backpressure
        do_read(4'h5, BASE + 32'h10, 3, 2'b01, 3'b010, 1,
                arc, fc, lc);
        check("t3_last", last_rdata, 7);

        // range boundary crossing
        for (int i = 0; i < 4; i++) begin
            wdat[i] = $urandom; wstb[i] = 4'hF;
        end
        addr = BASE + 32'((MEMW - 2) * 4);
        do_write(4'h6, addr, 3, 2'b01, 3'b010, -1, awc, wc, bc);
        check("t4_bresp", last_bresp, 2);
        do_read(4'h7, addr, 3, 2'b01, 3'b010, 1, arc, fc, lc);
        check("t4_last", last_rdata, 0);

        // below-base start: first two beats error
        do_read(4'h8, BASE - 32'd8, 3, 2'b01, 3'b010, 0,
                arc, fc, lc);
        check("t4b_last", last_rdata, 1);

        // byte strobes
        wdat[0] = 32'h11223344; wstb[0] = 4'hF;
        do_write(4'h1, BASE + 32'h100, 0, 2'b01, 3'b010, -1,
                 awc, wc, bc);
        wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
        do_write(4'h2, BASE + 32'h100, 0, 2'b01, 3'b010, -1,
                 awc, wc, bc);
        do_read(4'h3, BASE + 32'h100, 0, 2'b01, 3'b010, 0,
                arc, fc, lc);
`ifdef AXI_SRAM_WSTRB_EN
        exp_strobe = 32'h11BB33DD;
`else
        exp_strobe = 32'hAABBCCDD;
`endif
        check("t5_strobe", last_rdata, exp_strobe);

        // wlast mismatches: early and missing
        for (int i = 0; i < 2; i++) begin
            wdat[i] = $urandom; wstb[i] = 4'hF;
        end
        do_write(4'hA, BASE + 32'h200, 1, 2'b01, 3'b010, 0,
                 awc, wc, bc);
        check("t6_early", last_bresp, 2);
        do_write(4'hB, BASE + 32'h300, 1, 2'b01, 3'b010, 1,
                 awc, wc, bc);
        check("t6_missing", last_bresp, 2);
        do_read(4'hC, BASE + 32'h200, 1, 2'b01, 3'b010, 0,
                arc, fc, lc);

        // illegal burst type / size
        for (int i = 0; i < 2; i++) begin
            wdat[i] = $urandom; wstb[i] = 4'hF;
        end
        do_write(4'hD, BASE + 32'h200, 1, 2'b00, 3'b010, -1,
                 awc, wc, bc);
        check("t7_fixed", last_bresp, 2);
        do_read(4'hE, BASE + 32'h200, 1, 2'b01, 3'b010, 0,
                arc, fc, lc);
        do_read(4'hE, BASE + 32'h200, 1, 2'b10, 3'b010, 0,
                arc, fc, lc);
        do_read(4'hF, BASE + 32'h200, 1, 2'b01, 3'b001, 1,
                arc, fc, lc);

        // random bursts
        for (int n = 0; n < 8; n++) begin
            len = $urandom_range(15, 0);
            if (n % 3 == 0) word = MEMW - 1 - $urandom_range(8, 0);
            else word = $urandom_range(MEMW - 17, 0);
            addr = BASE + 32'(word * 4);
            for (int i = 0; i < 16; i++) begin
                wdat[i] = $urandom; wstb[i] = 4'hF;
            end
            do_write(4'(n), addr, len, 2'b01, 3'b010, -1,
                     awc, wc, bc);
            for (int i = 0; i < 16; i++) begin
                wdat[i] = $urandom;
                wstb[i] = 4'($urandom_range(15, 0));
            end
            do_write(4'(n + 1), addr, len,
                     (n == 5) ? 2'b10 : 2'b01, 3'b010, -1,
                     awc, wc, bc);
            do_read(4'(n + 2), addr, len, 2'b01,
                    (n == 6) ? 3'b011 : 3'b010, n % 2,
                    arc, fc, lc);
        end

        // reset during beat 2 of a len 7 read
        axs_arid = 4'h5; axs_araddr = BASE; axs_arlen = 4'd7;
        axs_arburst = 2'b01; axs_arsize = 3'b010;
        axs_arvalid = 1'b1;
        t = 0;
        while (!axs_arready && t < 50) begin step(); t++; end
        check("t9_ar_wait", 32'(t < 50), 1);
        step();
        axs_arvalid = 1'b0;
        axs_rready = 1'b1;
        beats = 0; t = 0;
        while (t < 50) begin
            if (axs_rvalid && beats == 2) break;
            if (axs_rvalid) beats++;
            step();
            t++;
        end
        check("t9_reach_beat2", 32'(t < 50), 1);
        reset = 1'b1;
        step();
        check("t9_rvalid", axs_rvalid, 0);
        check("t9_arready", axs_arready, 1);
        check("t9_rlast", axs_rlast, 0);
        check("t9_rid", axs_rid, 0);
        reset = 1'b0;
        axs_rready = 1'b0;
        step();
        check("t9_no_more", axs_rvalid, 0);

        // simultaneous write and read
        for (int i = 0; i < 4; i++) begin
            wdat[i] = $urandom; wstb[i] = 4'hF;
        end
        fork
            do_write(4'h9, BASE + 32'h400, 3, 2'b01, 3'b010, -1,
                     awc2, wc2, bc2);
            do_read(4'h6, BASE, 15, 2'b01, 3'b010, 0,
                    arc2, fc2, lc2);
        join
        check("t10_same_cycle", 32'(awc2), 32'(arc2));
        do_read(4'h3, BASE + 32'h400, 3, 2'b01, 3'b010, 1,
                arc, fc, lc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
